// File: rtl/fetch_sequencer_if.sv
// Bundle of decode, instruction-memory and status signals shared by the
// fetch sequencer (master side) and whatever drives/observes it (slave side).
interface fetch_sequencer_if #(
    parameter int ADDR_W = 26
);
    logic              branch;
    logic              zero;
    logic              jump;
    logic [ADDR_W-1:0] jaddr;
    logic [31:0]       boffset;
    logic              halt;
    logic              stall;
    logic              imem_ready;
    logic              imem_req;
    logic [31:0]       pc_index;
    logic              instr_valid;
    logic              redirect;
    logic              halted;

    modport master (
        input  branch, zero, jump, jaddr, boffset, halt, stall, imem_ready,
        output imem_req, pc_index, instr_valid, redirect, halted
    );

    modport slave (
        output branch, zero, jump, jaddr, boffset, halt, stall, imem_ready,
        input  imem_req, pc_index, instr_valid, redirect, halted
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: walks IDLE -> FETCH -> EXEC pairs, computes the
// next word index (sequential, taken branch or jump) and parks in HALT.
module fetch_sequencer #(
    parameter logic [31:0] RESET_INDEX = 32'd0,
    parameter int          ADDR_W      = 26
) (
    input  logic               clk,
    input  logic               reset,
    fetch_sequencer_if.master  bus,
    output logic [1:0]         fsm_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        redirect_q;
    logic        redirect_next;
    logic [31:0] jump_target;
    logic [31:0] branch_target;

    always_comb begin
        jump_target = '0;
        jump_target[ADDR_W-1:0] = bus.jaddr;
    end

    assign branch_target = pc + bus.boffset + 32'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pc         <= RESET_INDEX;
            redirect_q <= 1'b0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            redirect_q <= redirect_next;
        end
    end

    // Handshake: imem_req stays high for the whole FETCH state and the
    // instruction is accepted on the first posedge where imem_ready is also
    // high; instr_valid then holds through EXEC until stall drops.
    always_comb begin
        state_next    = state;
        pc_next       = pc;
        redirect_next = 1'b0;
        case (state)
            IDLE: state_next = FETCH;
            FETCH: begin
                if (bus.imem_ready) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (bus.stall) begin
                    state_next = EXEC;
                end else if (bus.halt) begin
                    state_next = HALT;
                end else begin
                    state_next = FETCH;
                    if (bus.branch && bus.zero) begin
                        pc_next       = branch_target;
                        redirect_next = 1'b1;
                    end else if (bus.jump) begin
                        pc_next       = jump_target + 32'd1;
                        redirect_next = 1'b1;
                    end else begin
                        pc_next = pc + 32'd1;
                    end
                end
            end
            HALT: state_next = HALT;
            default: state_next = IDLE;
        endcase
    end

    assign bus.imem_req    = (state == FETCH);
    assign bus.instr_valid = (state == EXEC);
    assign bus.halted      = (state == HALT);
    assign bus.pc_index    = pc;
    assign bus.redirect    = redirect_q;
    assign fsm_state       = state;

endmodule
